// File: rtl/weight_encode_loader.sv
// weight_encode_loader: encodes signed 8-bit weight rows to 5-bit PE codes, buffers a tile, shifts it into the array
module weight_encode_loader #(
  parameter int SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*SIZE-1:0]   W_row_in,
  input  logic                W_row_valid,
  output logic                W_row_ready,
  input  logic                Load_go,
  output logic [5*SIZE-1:0]   Weight_out,
  output logic                Weight_out_valid,
  output logic                Load_done,
  output logic                Clamp_flag
);
  localparam int RCW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam logic [RCW-1:0] LAST = RCW'(SIZE - 1);

  typedef enum logic [1:0] {FILL, WAIT_GO, LOAD} state_t;

  // returns {clamped, M, v[3:0]}
  function automatic logic [5:0] enc(input logic [7:0] w);
    logic signed [4:0] q;
    logic signed [4:0] c;
    logic [3:0] v;
    q = 5'(($signed({w[7], w}) + 9'sd8) >>> 4);
    c = q > 5'sd7 ? 5'sd7 : q < -5'sd7 ? -5'sd7 : q;
    v = c[4] ? 4'(c - 5'sd1) : c[3:0];
    return w == 8'd0 ? 6'b010000 :
           ($signed(w) > 8'sd15 || $signed(w) < -8'sd15) ? {q != c, 1'b1, v} :
           {2'b00, w[4:1] - {3'b000, ~w[0] & ~w[7]}};
  endfunction

  state_t               r_state, w_next;
  logic [RCW-1:0]       r_rc, w_rd;
  logic [5*SIZE-1:0]    r_buf [SIZE];
  logic [5*SIZE-1:0]    r_wout, w_code;
  logic [SIZE-1:0]      w_clamp;
  logic                 r_valid, r_done, r_clamp;
  logic                 w_accept, w_end;

  for (genvar j = 0; j < SIZE; j++) begin : g_lane
    assign {w_clamp[j], w_code[5*j +: 5]} = enc(W_row_in[8*j +: 8]);
  end

  assign W_row_ready      = r_state == FILL;
  assign Weight_out       = r_wout;
  assign Weight_out_valid = r_valid;
  assign Load_done        = r_done;
  assign Clamp_flag       = r_clamp;
  assign w_accept         = r_state == FILL && W_row_valid;
  assign w_end            = r_state == LOAD && r_rc == '0;
  assign w_rd             = r_state == LOAD ? r_rc - 1'b1 : r_rc;

  always_comb begin
    w_next = r_state;
    w_next = r_state == FILL    ? (w_accept && r_rc == LAST ? WAIT_GO : FILL) :
             r_state == WAIT_GO ? (Load_go ? LOAD : WAIT_GO) :
             (w_end ? FILL : LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  end

  // rc counts up while filling, then walks back down so rows leave SIZE-1 first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc    <= '0;
      r_wout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_clamp <= 1'b0;
    end else begin
      r_rc    <= w_accept && r_rc != LAST ? r_rc + 1'b1 :
                 r_state == LOAD && r_rc != '0 ? r_rc - 1'b1 : r_rc;
      r_valid <= w_next == LOAD;
      r_wout  <= w_next == LOAD ? r_buf[w_rd] : '0;
      r_done  <= w_end;
      r_clamp <= w_end ? 1'b0 : r_clamp | (w_accept & |w_clamp);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !rst) r_buf[r_rc] <= w_code;
  end
endmodule

// File: tb/tb_weight_encode_loader.sv
// tb_weight_encode_loader: randomized scoreboard bench for weight_encode_loader
module tb_weight_encode_loader;
  localparam int SIZE = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [8*SIZE-1:0]   W_row_in = '0;
  logic                W_row_valid = 1'b0;
  logic                W_row_ready;
  logic                Load_go = 1'b0;
  logic [5*SIZE-1:0]   Weight_out;
  logic                Weight_out_valid;
  logic                Load_done;
  logic                Clamp_flag;

  weight_encode_loader #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .W_row_in(W_row_in), .W_row_valid(W_row_valid),
    .W_row_ready(W_row_ready), .Load_go(Load_go), .Weight_out(Weight_out),
    .Weight_out_valid(Weight_out_valid), .Load_done(Load_done), .Clamp_flag(Clamp_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [5*SIZE-1:0] sb_q [$];
  logic [5*SIZE-1:0] m_buf [SIZE];
  bit m_clamp = 1'b0;
  int t_w [SIZE][SIZE];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference encoding from the arithmetic rules: returns {clamped, code}
  function automatic logic [5:0] model(input int w);
    int t, q, v;
    logic cl;
    if (w == 0) return 6'b010000;
    if (w >= -15 && w <= 15) begin
      t = (w % 2 != 0) ? w : (w > 0 ? w - 1 : w + 1);
      v = (t - 1) / 2;
      return {2'b00, v[3:0]};
    end
    q = (w + 8 + 256) / 16 - 16;
    cl = q > 7 || q < -7;
    q = q > 7 ? 7 : (q < -7 ? -7 : q);
    v = q >= 0 ? q : q - 1;
    return {cl, 1'b1, v[3:0]};
  endfunction

  function automatic int rw(input bit full);
    return full ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 239)) - 120;
  endfunction

  initial forever begin
    @(negedge clk);
    if (Weight_out_valid) begin
      if (sb_q.size() == 0) chk("unexpected_row", {63'd0, Weight_out_valid}, 64'd0);
      else chk("row_out", {24'd0, Weight_out}, {24'd0, sb_q.pop_front()});
    end else chk("idle_zero", {24'd0, Weight_out}, 64'd0);
  end

  task automatic send_row(input int r, input int go_at, output int waited);
    logic [5:0] e;
    @(negedge clk);
    for (int j = 0; j < SIZE; j++) W_row_in[8*j +: 8] = 8'(t_w[r][j]);
    W_row_valid = 1'b1;
    Load_go = (r == go_at);
    waited = 0;
    while (!W_row_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_timeout", {63'd0, W_row_ready}, 64'd1);
    @(posedge clk);
    for (int j = 0; j < SIZE; j++) begin
      e = model(t_w[r][j]);
      m_buf[r][5*j +: 5] = e[4:0];
      if (e[5]) m_clamp = 1'b1;
    end
  endtask

  task automatic fill_tile(input bit gaps, input int go_at, output int first_wait);
    int w;
    first_wait = 0;
    for (int r = 0; r < SIZE; r++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        W_row_valid = 1'b0;
        Load_go = 1'b0;
      end
      send_row(r, go_at, w);
      if (r == 0) first_wait = w;
    end
  endtask

  task automatic load_tile(input int hold, input bit bp);
    @(negedge clk);
    W_row_valid = bp;
    for (int i = 0; i < hold; i++) begin
      W_row_in = {$urandom, $urandom};
      chk("ready_wait", {63'd0, W_row_ready}, 64'd0);
      @(negedge clk);
    end
    W_row_valid = 1'b0;
    chk("ready_wait", {63'd0, W_row_ready}, 64'd0);
    chk("clamp_filled", {63'd0, Clamp_flag}, {63'd0, m_clamp});
    Load_go = 1'b1;
    for (int r = SIZE - 1; r >= 0; r--) sb_q.push_back(m_buf[r]);
    @(posedge clk);
    @(negedge clk);
    Load_go = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      chk("valid_load", {63'd0, Weight_out_valid}, 64'd1);
      chk("done_early", {63'd0, Load_done}, 64'd0);
      chk("clamp_load", {63'd0, Clamp_flag}, {63'd0, m_clamp});
      @(negedge clk);
    end
    chk("done_pulse", {63'd0, Load_done}, 64'd1);
    chk("valid_after", {63'd0, Weight_out_valid}, 64'd0);
    chk("clamp_cleared", {63'd0, Clamp_flag}, 64'd0);
    chk("ready_done", {63'd0, W_row_ready}, 64'd1);
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    m_clamp = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, Weight_out_valid}, 64'd0);
    chk("rst_wout", {24'd0, Weight_out}, 64'd0);
    chk("rst_done", {63'd0, Load_done}, 64'd0);
    chk("rst_clamp", {63'd0, Clamp_flag}, 64'd0);
    chk("rst_ready", {63'd0, W_row_ready}, 64'd1);
    rst = 1'b0;

    // encode corner values, no saturation; backpressure held through WAIT_GO
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b0);
    t_w[0][0] = 15;  t_w[0][1] = -15; t_w[0][2] = -1; t_w[0][3] = 0;
    t_w[0][4] = 2;   t_w[0][5] = 16;  t_w[0][6] = -16; t_w[0][7] = 40;
    fill_tile(1'b0, -1, w0);
    load_tile(3, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, Load_done}, 64'd0);

    // saturation
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b0);
    t_w[2][0] = 127; t_w[2][1] = -128; t_w[2][2] = -40;
    fill_tile(1'b1, -1, w0);
    load_tile(0, 1'b0);

    // row r = 2r+1, with Load_go pulsed during FILL
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = 2 * r + 1;
    fill_tile(1'b0, 3, w0);
    load_tile(2, 1'b1);

    // reset on the third valid cycle
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b1);
    t_w[1][1] = -128;
    fill_tile(1'b0, -1, w0);
    @(negedge clk);
    W_row_valid = 1'b0;
    Load_go = 1'b1;
    for (int r = SIZE - 1; r >= 0; r--) sb_q.push_back(m_buf[r]);
    @(posedge clk);
    @(negedge clk);
    Load_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    m_clamp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", {63'd0, Weight_out_valid}, 64'd0);
    chk("mid_rst_wout", {24'd0, Weight_out}, 64'd0);
    chk("mid_rst_done", {63'd0, Load_done}, 64'd0);
    chk("mid_rst_ready", {63'd0, W_row_ready}, 64'd1);
    chk("mid_rst_clamp", {63'd0, Clamp_flag}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", {63'd0, Load_done}, 64'd0);
    end

    // back-to-back tiles: clamped then clean, then clean then clamped
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b0);
    t_w[5][3] = 127;
    fill_tile(1'b0, -1, w0);
    load_tile(1, 1'b0);
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b0);
    fill_tile(1'b0, -1, w0);
    chk("b2b_wait", 64'(w0), 64'd0);
    load_tile(0, 1'b0);
    for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b0);
    t_w[7][7] = -128;
    fill_tile(1'b0, -1, w0);
    chk("b2b_wait", 64'(w0), 64'd0);
    load_tile(0, 1'b0);

    // random tiles across the full weight range
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < SIZE; r++) for (int j = 0; j < SIZE; j++) t_w[r][j] = rw(1'b1);
      fill_tile(1'b1, int'($urandom_range(0, SIZE - 2)), w0);
      load_tile(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
